// File: rtl/aes_mixcolumns_iter.sv
// aes_mixcolumns_iter: iterative, handshaked AES MixColumns engine.
// Transforms COLS_PER_CYCLE (1, 2 or 4) of the four state columns per clock.
// Optional feature macro: AES_MIXCOL_INV_EN builds the InvMixColumns path and
// lets in_inv choose the direction per block; without it every block is forward.
module aes_mixcolumns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("aes_mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // col_idx advances by the group size; for a group of four it wraps to 0.
    localparam logic [1:0] STEP       = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_START = 2'(4 - COLS_PER_CYCLE);
    localparam logic [2:0] GROUP_LEN  = 3'(COLS_PER_CYCLE);

    state_t         state_reg;
    state_t         state_next;
    logic [127:0]   data_reg;
    logic [127:0]   data_calc;
    logic [1:0]     col_idx_reg;
    logic           inv_q;
    logic           load;
    logic           last_group;

    // GF(2^8) helpers built from xtime chains, polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] a);
        return xtime(a) ^ a;
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ mul3(a1) ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ mul3(a2) ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ mul3(a3),
                mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

`ifdef AES_MIXCOL_INV_EN
    // Inverse coefficients: share x2/x4/x8 terms per byte.
    function automatic logic [31:0] mix_inv(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        logic [7:0] x2, x4, x8;
        {a[0], a[1], a[2], a[3]} = c;
        for (int i = 0; i < 4; i++) begin
            x2     = xtime(a[i]);
            x4     = xtime(x2);
            x8     = xtime(x4);
            m9[i]  = x8 ^ a[i];
            m11[i] = x8 ^ x2 ^ a[i];
            m13[i] = x8 ^ x4 ^ a[i];
            m14[i] = x8 ^ x4 ^ x2;
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction
`endif

    assign last_group = (col_idx_reg == LAST_START);
    assign load       = in_valid && in_ready;
    assign out_data   = data_reg;

    // Per-column datapath: a column is rewritten only when it lies in the active group.
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        logic [31:0] col_in;
        logic [31:0] col_out;
        logic        col_sel;

        assign col_in  = data_reg[127 - 32*gi -: 32];
        assign col_sel = (3'(gi) >= {1'b0, col_idx_reg}) &&
                         (3'(gi) <  ({1'b0, col_idx_reg} + GROUP_LEN));
`ifdef AES_MIXCOL_INV_EN
        assign col_out = inv_q ? mix_inv(col_in) : mix_fwd(col_in);
`else
        assign col_out = mix_fwd(col_in);
`endif
        assign data_calc[127 - 32*gi -: 32] = col_sel ? col_out : col_in;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs; in_ready follows out_ready only in DONE.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_group) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_next = in_valid ? CALC : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and column pointer: load on input handshake, update in place during CALC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_reg    <= '0;
            col_idx_reg <= '0;
        end else if (load) begin
            data_reg    <= in_data;
            col_idx_reg <= '0;
        end else if (state_reg == CALC) begin
            data_reg    <= data_calc;
            col_idx_reg <= col_idx_reg + STEP;
        end
    end

`ifdef AES_MIXCOL_INV_EN
    // Direction is captured with the block so in_inv may change afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else if (load) begin
            inv_q <= in_inv;
        end
    end
`else
    // Forward-only build: direction input is accepted but has no effect.
    assign inv_q = 1'b0;
    logic unused_inv;
    assign unused_inv = &{1'b0, in_inv, inv_q};
`endif

endmodule

// File: tb/tb_aes_mixcolumns_iter.sv
// Directed self-checking bench for aes_mixcolumns_iter (C=1 main instance,
// plus C=2 and C=4 instances sharing the inputs for latency checks).
module tb_aes_mixcolumns_iter;

    localparam logic [127:0] FWD_IN    = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FWD_OUT   = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] KNOWN_IN  = 128'hdb135345f20a225c01010101c6c6c6c6;
    localparam logic [127:0] KNOWN_OUT = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_inv;
    logic         out_ready;
    logic [127:0] in_data;

    logic         in_ready, out_valid, busy;
    logic [127:0] out_data;
    logic         c2_in_ready, c2_out_valid, c2_busy;
    logic [127:0] c2_out_data;
    logic         c4_in_ready, c4_out_valid, c4_busy;
    logic [127:0] c4_out_data;

    int checks = 0;
    int fails  = 0;

    aes_mixcolumns_iter #(.COLS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    aes_mixcolumns_iter #(.COLS_PER_CYCLE(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(c2_in_ready), .in_data(in_data), .in_inv(in_inv),
        .out_valid(c2_out_valid), .out_ready(out_ready), .out_data(c2_out_data), .busy(c2_busy)
    );

    aes_mixcolumns_iter #(.COLS_PER_CYCLE(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(c4_in_ready), .in_data(in_data), .in_inv(in_inv),
        .out_valid(c4_out_valid), .out_ready(out_ready), .out_data(c4_out_data), .busy(c4_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: bitwise shift-and-add GF(2^8) multiply and explicit circulant matrix.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   base [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (inv) begin
            base[0] = 8'd14; base[1] = 8'd11; base[2] = 8'd13; base[3] = 8'd9;
        end else begin
            base[0] = 8'd2;  base[1] = 8'd3;  base[2] = 8'd1;  base[3] = 8'd1;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(base[(j - row + 4) % 4], s[127 - 32*c - 8*j -: 8]);
                end
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Driver: one block through the C=1 instance with out_ready high; lat=-1 on timeout.
    task automatic run_block(input logic [127:0] d, input logic inv,
                             output logic [127:0] result, output int lat);
        int n;
        in_data = d; in_inv = inv; out_ready = 1'b1; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1; result = '0;
        for (int k = 1; k <= 20; k++) begin
            if (out_valid) begin
                lat = k; result = out_data;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0; in_data = '0;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (out_data !== 128'h0) begin fails++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_forward;
        int f1, f2, f4;
        logic [127:0] d1, d2, d4;
        in_data = FWD_IN; in_inv = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        checks++; if ({in_ready, c2_in_ready, c4_in_ready} !== 3'b111) begin
            fails++; $display("FAIL fwd_ready_all: got %b expected 111", {in_ready, c2_in_ready, c4_in_ready});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        f1 = -1; f2 = -1; f4 = -1; d1 = '0; d2 = '0; d4 = '0;
        for (int lat = 1; lat <= 8; lat++) begin
            if (out_valid && f1 < 0)    begin f1 = lat; d1 = out_data; end
            if (c2_out_valid && f2 < 0) begin f2 = lat; d2 = c2_out_data; end
            if (c4_out_valid && f4 < 0) begin f4 = lat; d4 = c4_out_data; end
            @(posedge clk); #1;
        end
        checks++; if (f1 !== 5) begin fails++; $display("FAIL fwd_lat_c1: got %0d expected 5", f1); end
        checks++; if (f2 !== 3) begin fails++; $display("FAIL fwd_lat_c2: got %0d expected 3", f2); end
        checks++; if (f4 !== 2) begin fails++; $display("FAIL fwd_lat_c4: got %0d expected 2", f4); end
        checks++; if (d1 !== FWD_OUT) begin fails++; $display("FAIL fwd_data_c1: got %h expected %h", d1, FWD_OUT); end
        checks++; if (d2 !== FWD_OUT) begin fails++; $display("FAIL fwd_data_c2: got %h expected %h", d2, FWD_OUT); end
        checks++; if (d4 !== FWD_OUT) begin fails++; $display("FAIL fwd_data_c4: got %h expected %h", d4, FWD_OUT); end
        $display("test_forward: lat c1=%0d c2=%0d c4=%0d data=%h", f1, f2, f4, d1);
    endtask

    task automatic test_inverse;
        logic [127:0] res, exp_v;
        int lat;
`ifdef AES_MIXCOL_INV_EN
        exp_v = FWD_IN;
`else
        exp_v = ref_mix(FWD_OUT, 1'b0);
`endif
        run_block(FWD_OUT, 1'b1, res, lat);
        checks++; if (lat !== 5) begin fails++; $display("FAIL inv_latency: got %0d expected 5", lat); end
        checks++; if (res !== exp_v) begin fails++; $display("FAIL inv_data: got %h expected %h", res, exp_v); end
        $display("test_inverse: in=%h out=%h", FWD_OUT, res);
    endtask

    task automatic test_known_columns;
        logic [127:0] res;
        int lat;
        run_block(KNOWN_IN, 1'b0, res, lat);
        checks++; if (lat !== 5) begin fails++; $display("FAIL known_latency: got %0d expected 5", lat); end
        checks++; if (res !== KNOWN_OUT) begin fails++; $display("FAIL known_data: got %h expected %h", res, KNOWN_OUT); end
        $display("test_known_columns: in=%h out=%h", KNOWN_IN, res);
    endtask

    task automatic test_backpressure;
        int lat;
        logic [127:0] res;
        in_data = FWD_IN; in_inv = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = KNOWN_IN;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (out_valid) begin lat = k; break; end
            @(posedge clk); #1;
        end
        checks++; if (lat !== 5) begin fails++; $display("FAIL bp_first_latency: got %0d expected 5", lat); end
        for (int k = 0; k < 10; k++) begin
            checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", k, out_valid); end
            checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_in_ready[%0d]: got %b expected 0", k, in_ready); end
            checks++; if (out_data !== FWD_OUT) begin fails++; $display("FAIL bp_hold_data[%0d]: got %h expected %h", k, out_data, FWD_OUT); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1; res = '0;
        for (int k = 1; k <= 20; k++) begin
            if (out_valid) begin lat = k; res = out_data; break; end
            @(posedge clk); #1;
        end
        checks++; if (lat !== 5) begin fails++; $display("FAIL bp_second_latency: got %0d expected 5", lat); end
        checks++; if (res !== KNOWN_OUT) begin fails++; $display("FAIL bp_second_data: got %h expected %h", res, KNOWN_OUT); end
        @(posedge clk); #1;
        $display("test_backpressure: second result %h after %0d cycles", res, lat);
    endtask

    task automatic test_back_to_back;
        logic [127:0] blk [8];
        logic [127:0] exp_v [8];
        int in_idx, out_idx, last_cyc;
        logic hs;
        for (int i = 0; i < 8; i++) begin
            blk[i]   = {$urandom, $urandom, $urandom, $urandom};
            exp_v[i] = ref_mix(blk[i], 1'b0);
        end
        in_inv = 1'b0; out_ready = 1'b1; in_idx = 0; out_idx = 0; last_cyc = -1;
        in_data = blk[0]; in_valid = 1'b1;
        for (int cyc = 0; cyc < 100 && out_idx < 8; cyc++) begin
            hs = in_valid && in_ready;
            if (out_valid) begin
                checks++; if (out_data !== exp_v[out_idx]) begin
                    fails++; $display("FAIL b2b_data[%0d]: got %h expected %h", out_idx, out_data, exp_v[out_idx]);
                end
                if (last_cyc >= 0) begin
                    checks++; if (cyc - last_cyc !== 5) begin
                        fails++; $display("FAIL b2b_interval[%0d]: got %0d expected 5", out_idx, cyc - last_cyc);
                    end
                end
                $display("b2b block %0d: out=%h cycle=%0d", out_idx, out_data, cyc);
                last_cyc = cyc;
                out_idx++;
            end
            @(posedge clk); #1;
            if (hs) begin
                in_idx++;
                if (in_idx < 8) in_data = blk[in_idx];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++; if (out_idx !== 8) begin fails++; $display("FAIL b2b_count: got %0d expected 8", out_idx); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic [127:0] res;
        int lat;
        in_data = FWD_IN; in_inv = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 128'h0) begin fails++; $display("FAIL mid_out_data: got %h expected 0", out_data); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy_after: got %b expected 0", busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(KNOWN_IN, 1'b0, res, lat);
        checks++; if (lat !== 5) begin fails++; $display("FAIL mid_after_latency: got %0d expected 5", lat); end
        checks++; if (res !== KNOWN_OUT) begin fails++; $display("FAIL mid_after_data: got %h expected %h", res, KNOWN_OUT); end
        $display("test_reset_mid: post-reset result %h", res);
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_known_columns();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
